// File: rtl/sobel_window_reader.sv
// Raster-scan read master for the greyscale frame buffer: fetches 3x3 windows and streams Sobel magnitudes.
// Build option SOBEL_THRESHOLD_EN: output a binary edge map (mag >= THRESH) instead of saturated magnitude.
module sobel_window_reader #(
    parameter int          WIDTH   = 768,
    parameter int          HEIGHT  = 512,
    parameter int          COORD_W = 11,
    parameter logic [7:0]  THRESH  = 8'd100
) (
    input  logic               CAMERA_CLK,
    input  logic               HRESETn,
    input  logic               start,
    output logic               readWrite,
    output logic [COORD_W-1:0] coordinate_X,
    output logic [COORD_W-1:0] coordinate_Y,
    input  logic [7:0]         ul,
    input  logic [7:0]         uc,
    input  logic [7:0]         ur,
    input  logic [7:0]         ml,
    input  logic [7:0]         mc,
    input  logic [7:0]         mr,
    input  logic [7:0]         dl,
    input  logic [7:0]         dc,
    input  logic [7:0]         dr,
    input  logic [COORD_W-1:0] outX,
    input  logic [COORD_W-1:0] outY,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [7:0]         pix_data,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               busy,
    output logic               frame_done,
    output logic               align_err,
    output logic [2:0]         dbg_state
);

    // Output stream: a pixel transfers on a rising edge where pix_valid && pix_ready;
    // pix_data/pix_x/pix_y are held while pix_valid is high and pix_ready is low.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_COMPUTE = 3'd3,
        S_OUTPUT  = 3'd4,
        S_BORDER  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(HEIGHT - 1);

    state_t             state, state_n;
    logic [COORD_W-1:0] row, col;
    logic [COORD_W-1:0] nxt_row, nxt_col;
    logic               last_col, last_pix, nxt_border;
    logic [7:0]         w_ul, w_uc, w_ur, w_ml, w_mr, w_dl, w_dc, w_dr;
    logic [10:0]        gx_pos, gx_neg, gy_pos, gy_neg, gx, gy, abs_x, abs_y, mag;
    logic [7:0]         edge_val;

    // The center tap contributes to neither kernel.
    logic [7:0] unused_center;
    assign unused_center = mc;

    assign dbg_state = state;

    always_comb begin
        last_col   = (col == LAST_COL);
        last_pix   = last_col && (row == LAST_ROW);
        nxt_col    = last_col ? '0 : col + COORD_W'(1);
        nxt_row    = last_col ? row + COORD_W'(1) : row;
        nxt_border = (nxt_row == '0) || (nxt_row == LAST_ROW) ||
                     (nxt_col == '0) || (nxt_col == LAST_COL);
    end

    always_ff @(posedge CAMERA_CLK) begin
        if (!HRESETn) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n    = state;
        pix_valid  = 1'b0;
        busy       = 1'b1;
        readWrite  = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                busy      = 1'b0;
                readWrite = 1'b1;
                if (start) state_n = S_BORDER;
            end
            S_ISSUE:   state_n = S_CAPTURE;
            S_CAPTURE: state_n = S_COMPUTE;
            S_COMPUTE: state_n = S_OUTPUT;
            S_BORDER:  state_n = S_OUTPUT;
            S_OUTPUT: begin
                pix_valid = 1'b1;
                if (pix_ready) begin
                    if (last_pix)        state_n = S_DONE;
                    else if (nxt_border) state_n = S_BORDER;
                    else                 state_n = S_ISSUE;
                end
            end
            S_DONE: begin
                busy       = 1'b0;
                readWrite  = 1'b1;
                frame_done = 1'b1;
                state_n    = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Differences are formed in 11-bit two's complement; the true range (+/-1020) never wraps.
    always_comb begin
        gx_pos = {3'b0, w_ur} + {2'b0, w_mr, 1'b0} + {3'b0, w_dr};
        gx_neg = {3'b0, w_ul} + {2'b0, w_ml, 1'b0} + {3'b0, w_dl};
        gy_pos = {3'b0, w_dl} + {2'b0, w_dc, 1'b0} + {3'b0, w_dr};
        gy_neg = {3'b0, w_ul} + {2'b0, w_uc, 1'b0} + {3'b0, w_ur};
        gx     = gx_pos - gx_neg;
        gy     = gy_pos - gy_neg;
        abs_x  = gx[10] ? (11'd0 - gx) : gx;
        abs_y  = gy[10] ? (11'd0 - gy) : gy;
        mag    = abs_x + abs_y;
`ifdef SOBEL_THRESHOLD_EN
        edge_val = (mag >= {3'b0, THRESH}) ? 8'hFF : 8'h00;
`else
        edge_val = (mag > 11'd255) ? 8'hFF : mag[7:0];
`endif
    end

`ifndef SOBEL_THRESHOLD_EN
    logic [7:0] unused_thresh;
    assign unused_thresh = THRESH;
`endif

    always_ff @(posedge CAMERA_CLK) begin
        if (!HRESETn) begin
            row          <= '0;
            col          <= '0;
            coordinate_X <= '0;
            coordinate_Y <= '0;
            pix_data     <= 8'h00;
            pix_x        <= '0;
            pix_y        <= '0;
            align_err    <= 1'b0;
            w_ul <= 8'h00; w_uc <= 8'h00; w_ur <= 8'h00; w_ml <= 8'h00;
            w_mr <= 8'h00; w_dl <= 8'h00; w_dc <= 8'h00; w_dr <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        row <= '0;
                        col <= '0;
                    end
                end
                S_CAPTURE: begin
                    w_ul <= ul; w_uc <= uc; w_ur <= ur; w_ml <= ml;
                    w_mr <= mr; w_dl <= dl; w_dc <= dc; w_dr <= dr;
                    if ((outX != row) || (outY != col)) align_err <= 1'b1;
                end
                S_COMPUTE: begin
                    pix_data <= edge_val;
                    pix_x    <= row;
                    pix_y    <= col;
                end
                S_BORDER: begin
                    pix_data <= 8'h00;
                    pix_x    <= row;
                    pix_y    <= col;
                end
                S_OUTPUT: begin
                    // Coordinates move only when an interior window is about to be requested.
                    if (pix_ready && !last_pix) begin
                        row <= nxt_row;
                        col <= nxt_col;
                        if (!nxt_border) begin
                            coordinate_X <= nxt_row;
                            coordinate_Y <= nxt_col;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_window_reader.sv
// Bench for sobel_window_reader on an 8x6 frame with a registered 3x3 window buffer model.
module tb_sobel_window_reader;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int CW = 11;
`ifdef SOBEL_THRESHOLD_EN
    localparam logic [7:0] SINGLE_EXP = 8'd0;
`else
    localparam logic [7:0] SINGLE_EXP = 8'd20;
`endif

    logic          CAMERA_CLK;
    logic          HRESETn;
    logic          start;
    logic          readWrite;
    logic [CW-1:0] coordinate_X, coordinate_Y;
    logic [7:0]    ul, uc, ur, ml, mc, mr, dl, dc, dr;
    logic [CW-1:0] outX, outY;
    logic          pix_valid, pix_ready;
    logic [7:0]    pix_data;
    logic [CW-1:0] pix_x, pix_y;
    logic          busy, frame_done, align_err;
    logic [2:0]    dbg_state;

    sobel_window_reader #(.WIDTH(W), .HEIGHT(H), .COORD_W(CW), .THRESH(8'd100)) dut (
        .CAMERA_CLK(CAMERA_CLK), .HRESETn(HRESETn), .start(start), .readWrite(readWrite),
        .coordinate_X(coordinate_X), .coordinate_Y(coordinate_Y),
        .ul(ul), .uc(uc), .ur(ur), .ml(ml), .mc(mc), .mr(mr), .dl(dl), .dc(dc), .dr(dr),
        .outX(outX), .outY(outY), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .busy(busy),
        .frame_done(frame_done), .align_err(align_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial CAMERA_CLK = 1'b0;
    always #5 CAMERA_CLK = ~CAMERA_CLK;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- buffer model ----------------
    logic [7:0] frame   [H][W];
    logic [7:0] exp_map [H][W];
    bit         misalign;

    always @(posedge CAMERA_CLK) begin
        int x, y;
        x = int'(coordinate_X);
        y = int'(coordinate_Y);
        if (x >= 1 && x <= H - 2 && y >= 1 && y <= W - 2) begin
            ul <= frame[x-1][y-1]; uc <= frame[x-1][y]; ur <= frame[x-1][y+1];
            ml <= frame[x][y-1];   mc <= frame[x][y];   mr <= frame[x][y+1];
            dl <= frame[x+1][y-1]; dc <= frame[x+1][y]; dr <= frame[x+1][y+1];
        end
        outX <= coordinate_X;
        outY <= coordinate_Y + ((misalign && x == 3 && y == 3) ? CW'(1) : CW'(0));
    end

    // ---------------- scoreboard ----------------
    logic [2*CW+7:0] exp_q[$];
    logic [2*CW+7:0] sb_e;
    int checks, failures;
    int cyc, pix_cnt, done_cnt, last_hs_cyc;
    bit first_pix, gap_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic bit is_border(input int r, input int c);
        return (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
    endfunction

    always @(posedge CAMERA_CLK) cyc <= cyc + 1;

    always @(negedge CAMERA_CLK) begin
        #2;
        if (HRESETn) begin
            if (frame_done) done_cnt++;
            if (pix_valid && pix_ready) begin
                pix_cnt++;
                check("rw_during_scan", readWrite, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_extra actual=pixel(%0d,%0d) required=none", pix_x, pix_y);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("pix_x", pix_x, sb_e[2*CW+7:CW+8]);
                    check("pix_y", pix_y, sb_e[CW+7:8]);
                    check("pix_data", pix_data, sb_e[7:0]);
                end
                if (gap_en && !first_pix)
                    check("hs_gap", cyc - last_hs_cyc, is_border(int'(pix_x), int'(pix_y)) ? 2 : 4);
                first_pix   = 1'b0;
                last_hs_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus tables ----------------
    typedef struct {
        int         row;
        int         col;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[$];

    // pattern 0: uniform 0x80, 1: vertical step, 2: single pixel of 10 at (2,3)
    task automatic load_frame(input int pattern);
        vecs.delete();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                case (pattern)
                    0:       frame[r][c] = 8'h80;
                    1:       frame[r][c] = (c >= 4) ? 8'd200 : 8'd0;
                    default: frame[r][c] = (r == 2 && c == 3) ? 8'd10 : 8'd0;
                endcase
                exp_map[r][c] = 8'd0;
            end
        if (pattern == 1) begin
            for (int r = 1; r <= H - 2; r++) begin
                vecs.push_back('{r, 1, 8'd0});   vecs.push_back('{r, 2, 8'd0});
                vecs.push_back('{r, 3, 8'd255}); vecs.push_back('{r, 4, 8'd255});
                vecs.push_back('{r, 5, 8'd0});   vecs.push_back('{r, 6, 8'd0});
            end
        end else if (pattern == 2) begin
            vecs.push_back('{1, 2, SINGLE_EXP}); vecs.push_back('{1, 3, SINGLE_EXP});
            vecs.push_back('{1, 4, SINGLE_EXP}); vecs.push_back('{2, 2, SINGLE_EXP});
            vecs.push_back('{2, 3, 8'd0});       vecs.push_back('{2, 4, SINGLE_EXP});
            vecs.push_back('{3, 2, SINGLE_EXP}); vecs.push_back('{3, 3, SINGLE_EXP});
            vecs.push_back('{3, 4, SINGLE_EXP});
        end
        for (int i = 0; i < vecs.size(); i++) exp_map[vecs[i].row][vecs[i].col] = vecs[i].exp;
        exp_q.delete();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) exp_q.push_back({CW'(r), CW'(c), exp_map[r][c]});
    endtask

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        HRESETn   = 1'b0;
        start     = 1'b0;
        pix_ready = 1'b1;
        repeat (3) @(negedge CAMERA_CLK);
        HRESETn = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_readWrite"}, readWrite, 1);
        check({tag, "_coord_x"}, coordinate_X, 0);
        check({tag, "_coord_y"}, coordinate_Y, 0);
        check({tag, "_pix_valid"}, pix_valid, 0);
        check({tag, "_pix_data"}, pix_data, 0);
        check({tag, "_pix_x"}, pix_x, 0);
        check({tag, "_pix_y"}, pix_y, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_align_err"}, align_err, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    task automatic start_frame();
        @(negedge CAMERA_CLK);
        pix_cnt   = 0;
        done_cnt  = 0;
        first_pix = 1'b1;
        start     = 1'b1;
        @(negedge CAMERA_CLK);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (n < 400) begin
            @(negedge CAMERA_CLK);
            if (frame_done) break;
            n++;
        end
        if (n >= 400) begin
            checks++;
            failures++;
            $display("FAIL %s_done_timeout actual=no_frame_done required=frame_done", tag);
        end
    endtask

    task automatic wait_pixel(input int r, input int c);
        int n;
        n = 0;
        while (n < 300) begin
            @(negedge CAMERA_CLK);
            if (pix_valid && pix_x == CW'(r) && pix_y == CW'(c)) break;
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL wait_pixel_timeout actual=none required=(%0d,%0d)", r, c);
        end
    endtask

    task automatic end_of_frame(input string tag);
        check({tag, "_done_busy"}, busy, 0);
        check({tag, "_done_rw"}, readWrite, 1);
        repeat (2) @(negedge CAMERA_CLK);
        check({tag, "_pix_count"}, pix_cnt, W * H);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    // ---------------- test sequence ----------------
    logic [7:0]    snap_d;
    logic [CW-1:0] snap_x, snap_y, snap_cx, snap_cy;
    int            done_snap;

    initial begin
        misalign = 1'b0;
        gap_en   = 1'b1;
        load_frame(0);
        reset_dut();
        check_reset_vals("reset");

        // 1: uniform frame, with a start pulse while busy
        start_frame();
        check("t1_busy_after_start", busy, 1);
        check("t1_rw_after_start", readWrite, 0);
        check("t1_valid_in_border", pix_valid, 0);
        @(negedge CAMERA_CLK);
        check("t1_border_latency_valid", pix_valid, 1);
        repeat (20) @(negedge CAMERA_CLK);
        start = 1'b1;
        @(negedge CAMERA_CLK);
        start = 1'b0;
        wait_done("t1");
        check("t1_align_err", align_err, 0);
        end_of_frame("t1");

        // 2: vertical step, start coinciding with frame_done is ignored
        load_frame(1);
        start_frame();
        wait_done("t2");
        start = 1'b1;
        @(negedge CAMERA_CLK);
        start = 1'b0;
        check("t2_start_at_done_busy", busy, 0);
        @(negedge CAMERA_CLK);
        check("t2_start_at_done_state", dbg_state, 0);
        check("t2_pix_count", pix_cnt, W * H);
        check("t2_queue_left", exp_q.size(), 0);

        // 3: single bright pixel
        load_frame(2);
        start_frame();
        wait_done("t3");
        end_of_frame("t3");

        // 4: backpressure at (1,1)
        load_frame(1);
        gap_en = 1'b0;
        start_frame();
        wait_pixel(1, 1);
        pix_ready = 1'b0;
        snap_d  = pix_data;
        snap_x  = pix_x;
        snap_y  = pix_y;
        snap_cx = coordinate_X;
        snap_cy = coordinate_Y;
        check("t4_stall_coord_x", snap_cx, 1);
        check("t4_stall_coord_y", snap_cy, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CAMERA_CLK);
            check("t4_stall_valid", pix_valid, 1);
            check("t4_stall_data", pix_data, snap_d);
            check("t4_stall_x", pix_x, snap_x);
            check("t4_stall_y", pix_y, snap_y);
            check("t4_stall_cx", coordinate_X, snap_cx);
            check("t4_stall_cy", coordinate_Y, snap_cy);
            check("t4_stall_rw", readWrite, 0);
            if (i < 4) pix_ready = 1'b0;
        end
        pix_ready = 1'b1;
        wait_done("t4");
        end_of_frame("t4");
        gap_en = 1'b1;

        // 5: buffer echoes a wrong column at (3,3)
        load_frame(0);
        misalign = 1'b1;
        start_frame();
        wait_pixel(3, 2);
        check("t5_align_before", align_err, 0);
        wait_done("t5");
        check("t5_align_set", align_err, 1);
        end_of_frame("t5");
        misalign = 1'b0;
        repeat (3) @(negedge CAMERA_CLK);
        check("t5_align_sticky", align_err, 1);

        // 6: reset in the middle of pixel (2,5), then a clean rescan
        load_frame(1);
        start_frame();
        wait_pixel(2, 5);
        HRESETn = 1'b0;
        done_snap = done_cnt;
        @(negedge CAMERA_CLK);
        check_reset_vals("t6_in_reset");
        HRESETn = 1'b1;
        repeat (3) @(negedge CAMERA_CLK);
        check_reset_vals("t6_after_reset");
        check("t6_no_partial_done", done_cnt, done_snap);
        load_frame(1);
        start_frame();
        wait_done("t6");
        end_of_frame("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
